buffer_command_ctrl: RTL and testbench
======================================

BUFFER_COMMAND_CTRL -- requirements
Module: buffer_command_ctrl

Interface
REQ-001 SHALL have parameter NUM_BUFFERS, default 2, number of attached frame buffers (color, depth, ...; range 1-4).
REQ-002 SHALL have parameter CLEAR_WIDTH, default 16, bit width of each buffer's clear value.
REQ-003 SHALL have parameter NUM_TILES, default 1, count of Y_LINE_RESOLUTION subparts per screen (range 1-256).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, applied-wait limit (used only with the macro in REQ-020).
REQ-005 Ports, in this order:
- aclk  in  1  clock; the block has one clock.
- resetn  in  1  reset; synchronous, active-low.
- s_cmd_tvalid  in  1  command valid.
- s_cmd_tready  out  1  command accepted.
- s_cmd_commit  in  1  stream buffer out.
- s_cmd_memset  in  1  clear buffer.
- s_cmd_mask  in  NUM_BUFFERS  target buffers.
- s_cmd_clear  in  NUM_BUFFERS*CLEAR_WIDTH  clear values; buffer i in slice i.
- pixelInPipeline  in  1  fragments in flight.
- apply  out  NUM_BUFFERS  per-buffer apply request.
- applied  in  NUM_BUFFERS  per-buffer completion.
- cmdCommit  out  NUM_BUFFERS  registered commit flag.
- cmdMemset  out  NUM_BUFFERS  registered memset flag.
- clearValue  out  NUM_BUFFERS*CLEAR_WIDTH  registered clear values.
- tileIndex  out  $clog2(NUM_TILES)+1  current screen subpart.
- frameDone  out  1  one-cycle pulse after last tile committed.
- busy  out  1  state not IDLE.
- error  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement states IDLE, DRAIN, APPLY, DONE.
REQ-007 IDLE: s_cmd_tready=1; on tvalid&&tready, SHALL latch commit, memset, mask, clear into registers, go to DRAIN.
REQ-008 Command with mask==0 or commit==memset==0 SHALL be accepted and discarded; stay IDLE, no other output change.
REQ-009 DRAIN: SHALL hold until pixelInPipeline==0, then go to APPLY next cycle; minimum DRAIN residency 1 cycle.
REQ-010 APPLY: apply[i] SHALL be 1 for every masked buffer i whose pending bit is set; pending initialised from mask on DRAIN->APPLY.
REQ-011 Pending bit i SHALL clear, and apply[i] drop, on the cycle after applied[i]==1 is sampled; applied on unmasked buffers SHALL be ignored.
REQ-012 When pending==0 SHALL go to DONE; DONE lasts exactly 1 cycle, then IDLE.
REQ-013 In DONE with latched commit==1, tileIndex SHALL increment; at NUM_TILES-1 it SHALL wrap to 0 and frameDone SHALL pulse 1 cycle in the same DONE cycle.
REQ-014 Memset-only commands SHALL NOT advance tileIndex.
REQ-015 cmdCommit, cmdMemset, clearValue SHALL be stable from DRAIN entry until IDLE re-entry.
REQ-016 Latency, tvalid accept to apply rising, with pixelInPipeline=0 and applied returned the cycle apply rises: 2 cycles. IDLE to IDLE: 5 cycles.
REQ-017 s_cmd_tready SHALL be 0 in every state but IDLE; no command queuing.

Reset
REQ-018 On resetn==0 at a clock edge: state IDLE; apply, cmdCommit, cmdMemset, pending 0. clearValue, tileIndex 0. frameDone, busy, error 0.
REQ-019 Reset mid-APPLY SHALL drop apply on the next edge and abandon the command; no frameDone.

Configuration
REQ-020 With BUFFER_CMD_TIMEOUT_EN defined:
- a counter SHALL run while in APPLY.
- If it reaches TIMEOUT_CYCLES, error SHALL set (sticky until reset), pending clears, state goes to DONE; tileIndex not advanced.
- Without the macro: no counter, error tied 0, APPLY waits indefinitely.

Structure
REQ-021 State encoding and CMD field positions SHALL live in the shared package BufferCommandDefines.
REQ-022 Tile counter SHALL be sub-module tile_counter: increment, wrap, and last-tile pulse.

Verification
REQ-023 NUM_BUFFERS=2, commit mask=2'b11, pixelInPipeline=0, applied returned after 3 cycles -> apply=2'b11 for 3 cycles, then DONE, tileIndex 0->1.
REQ-024 Memset mask=2'b10, clear={16'hFFFF,16'h0000}, pixelInPipeline high 10 cycles -> apply stays 0 for 10 cycles, then apply=2'b10, clearValue[31:16]=16'hFFFF, tileIndex unchanged.
REQ-025 NUM_TILES=4, four commits -> tileIndex 1,2,3,0; frameDone pulses once, on the fourth DONE.
REQ-026 applied[0] 2 cycles before applied[1] -> apply[0] drops first, apply[1] remains until its applied; single DONE.
REQ-027 With BUFFER_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8, applied never asserted -> error=1 after 8 APPLY cycles, return to IDLE; s_cmd_tready=1.
REQ-028 resetn low during APPLY -> next edge apply=0, busy=0, s_cmd_tready=1, tileIndex=0.

Source files
------------

// File: rtl/buffer_command_ctrl_pkg.sv
// Shared definitions for buffer_command_ctrl: controller state encoding and
// the bit positions of the command flags inside a packed flag word.
package BufferCommandDefines;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } bufCmdState_t;

    localparam int CMD_COMMIT_POS = 0;
    localparam int CMD_MEMSET_POS = 1;
    localparam int CMD_FLAGS_W    = 2;

    function automatic logic [CMD_FLAGS_W-1:0] packCmdFlags(input logic commit, input logic memset);
        logic [CMD_FLAGS_W-1:0] flags;
        flags                 = '0;
        flags[CMD_COMMIT_POS] = commit;
        flags[CMD_MEMSET_POS] = memset;
        return flags;
    endfunction

endpackage

// File: rtl/buffer_command_ctrl_tile_counter.sv
// Screen-subpart counter: advances once per committed command, wraps after the
// last tile and reports the wrap combinationally in the advancing cycle.
module tile_counter #(
    parameter int NUM_TILES = 1,
    parameter int IDX_W     = $clog2(NUM_TILES) + 1
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_inc,
    output logic [IDX_W-1:0] o_index,
    output logic             o_wrap
);

    logic [IDX_W-1:0] r_index;
    logic             w_atLast;

    assign w_atLast = (r_index == IDX_W'(NUM_TILES - 1));
    assign o_wrap   = i_inc && w_atLast;
    assign o_index  = r_index;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_index <= '0;
        end else if (i_inc) begin
            r_index <= w_atLast ? '0 : r_index + IDX_W'(1);
        end
    end

endmodule

// File: rtl/buffer_command_ctrl.sv
// Frame-buffer command controller: drains the pixel pipeline, requests per-buffer
// commit/memset, tracks tiles. Optional APPLY watchdog via BUFFER_CMD_TIMEOUT_EN.
module buffer_command_ctrl
    import BufferCommandDefines::*;
#(
    parameter int NUM_BUFFERS    = 2,
    parameter int CLEAR_WIDTH    = 16,
    parameter int NUM_TILES      = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                               aclk,
    input  logic                               resetn,
    input  logic                               s_cmd_tvalid,
    output logic                               s_cmd_tready,
    input  logic                               s_cmd_commit,
    input  logic                               s_cmd_memset,
    input  logic [NUM_BUFFERS-1:0]             s_cmd_mask,
    input  logic [NUM_BUFFERS*CLEAR_WIDTH-1:0] s_cmd_clear,
    input  logic                               pixelInPipeline,
    output logic [NUM_BUFFERS-1:0]             apply,
    input  logic [NUM_BUFFERS-1:0]             applied,
    output logic [NUM_BUFFERS-1:0]             cmdCommit,
    output logic [NUM_BUFFERS-1:0]             cmdMemset,
    output logic [NUM_BUFFERS*CLEAR_WIDTH-1:0] clearValue,
    output logic [$clog2(NUM_TILES):0]         tileIndex,
    output logic                               frameDone,
    output logic                               busy,
    output logic                               error
);

    localparam int TILE_W = $clog2(NUM_TILES) + 1;

    bufCmdState_t                     r_state;
    bufCmdState_t                     w_nextState;
    logic [NUM_BUFFERS-1:0]           r_mask;
    logic [NUM_BUFFERS-1:0]           r_pending;
    logic [NUM_BUFFERS-1:0]           w_nextPending;
    logic [NUM_BUFFERS-1:0]           r_cmdCommit;
    logic [NUM_BUFFERS-1:0]           r_cmdMemset;
    logic [NUM_BUFFERS*CLEAR_WIDTH-1:0] r_clear;
    logic                             r_isCommit;
    logic [CMD_FLAGS_W-1:0]           w_flags;
    logic                             w_accept;
    logic                             w_timeoutHit;
    logic                             w_abandoned;
    logic                             w_tileInc;
    logic                             w_wrap;

    assign w_flags  = packCmdFlags(s_cmd_commit, s_cmd_memset);
    // Empty masks and flagless commands are consumed here but never leave IDLE.
    assign w_accept = s_cmd_tvalid && (r_state == ST_IDLE) && (|s_cmd_mask) && (|w_flags);

`ifdef BUFFER_CMD_TIMEOUT_EN
    logic [31:0] r_timer;
    logic        r_error;
    logic        r_timedOut;

    assign w_timeoutHit = (r_state == ST_APPLY) && (|r_pending)
                          && (r_timer == 32'(TIMEOUT_CYCLES - 1));
    assign w_abandoned  = r_timedOut;
    assign error        = r_error;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_timer    <= '0;
            r_error    <= 1'b0;
            r_timedOut <= 1'b0;
        end else begin
            r_timer <= (r_state == ST_APPLY) ? r_timer + 32'd1 : 32'd0;
            if (w_timeoutHit) begin
                r_error    <= 1'b1;
                r_timedOut <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_timedOut <= 1'b0;
            end
        end
    end
`else
    assign w_timeoutHit = 1'b0;
    assign w_abandoned  = 1'b0;
    assign error        = 1'b0;
`endif

    always_comb begin
        w_nextState   = r_state;
        w_nextPending = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_nextState = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pixelInPipeline) begin
                    w_nextState   = ST_APPLY;
                    w_nextPending = r_mask;
                end
            end
            ST_APPLY: begin
                w_nextPending = r_pending & ~applied;
                if (r_pending == '0) begin
                    w_nextState = ST_DONE;
                end else if (w_timeoutHit) begin
                    w_nextPending = '0;
                    w_nextState   = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState   = ST_IDLE;
                w_nextPending = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_mask      <= '0;
            r_cmdCommit <= '0;
            r_cmdMemset <= '0;
            r_clear     <= '0;
            r_isCommit  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_pending <= w_nextPending;
            if (w_accept) begin
                r_mask      <= s_cmd_mask;
                r_cmdCommit <= w_flags[CMD_COMMIT_POS] ? s_cmd_mask : '0;
                r_cmdMemset <= w_flags[CMD_MEMSET_POS] ? s_cmd_mask : '0;
                r_clear     <= s_cmd_clear;
                r_isCommit  <= w_flags[CMD_COMMIT_POS];
            end
        end
    end

    assign w_tileInc = (r_state == ST_DONE) && r_isCommit && !w_abandoned;

    tile_counter #(
        .NUM_TILES (NUM_TILES),
        .IDX_W     (TILE_W)
    ) u_tileCounter (
        .i_clk    (aclk),
        .i_resetn (resetn),
        .i_inc    (w_tileInc),
        .o_index  (tileIndex),
        .o_wrap   (w_wrap)
    );

    assign apply        = r_pending;
    assign cmdCommit    = r_cmdCommit;
    assign cmdMemset    = r_cmdMemset;
    assign clearValue   = r_clear;
    assign frameDone    = w_wrap;
    assign busy         = (r_state != ST_IDLE);
    assign s_cmd_tready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_buffer_command_ctrl.sv
// Self-checking bench for buffer_command_ctrl (2 buffers, 4 tiles): directed table,
// randomized commands against a transaction-level model, reset and timeout sequences.
module tb_buffer_command_ctrl;

    logic        aclk;
    logic        resetn;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic        s_cmd_commit;
    logic        s_cmd_memset;
    logic [1:0]  s_cmd_mask;
    logic [31:0] s_cmd_clear;
    logic        pixelInPipeline;
    logic [1:0]  apply;
    logic [1:0]  applied;
    logic [1:0]  cmdCommit;
    logic [1:0]  cmdMemset;
    logic [31:0] clearValue;
    logic [2:0]  tileIndex;
    logic        frameDone;
    logic        busy;
    logic        error;

    int vectorsApplied = 0;
    int miscompares    = 0;

    typedef struct {
        logic        commit;
        logic        memset;
        logic [1:0]  mask;
        logic [31:0] clear;
        int          drain;
        int          k0;
        int          k1;
        int          expBusy;
        int          expStart;
        int          expFrameDone;
        logic [2:0]  expTile;
        logic [1:0]  expCmdCommit;
        logic [1:0]  expCmdMemset;
        logic [31:0] expClear;
    } vec_t;

    vec_t table_[7];

    int          modelTile;
    logic [1:0]  lastCommit;
    logic [1:0]  lastMemset;
    logic [31:0] lastClear;

    buffer_command_ctrl #(
        .NUM_BUFFERS    (2),
        .CLEAR_WIDTH    (16),
        .NUM_TILES      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .s_cmd_tvalid    (s_cmd_tvalid),
        .s_cmd_tready    (s_cmd_tready),
        .s_cmd_commit    (s_cmd_commit),
        .s_cmd_memset    (s_cmd_memset),
        .s_cmd_mask      (s_cmd_mask),
        .s_cmd_clear     (s_cmd_clear),
        .pixelInPipeline (pixelInPipeline),
        .apply           (apply),
        .applied         (applied),
        .cmdCommit       (cmdCommit),
        .cmdMemset       (cmdMemset),
        .clearValue      (clearValue),
        .tileIndex       (tileIndex),
        .frameDone       (frameDone),
        .busy            (busy),
        .error           (error)
    );

    // Free-running clock, 10 time units per period
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Hard stop in case something unbounded slips through
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point: every check counts here
    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectorsApplied++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: derives timing and register expectations from
    // the command rules (drain time, slowest masked buffer, fixed DONE cycle)
    task automatic modelExpect(inout vec_t v);
        int maxK;
        v.expFrameDone = 0;
        v.expStart     = -1;
        v.expBusy      = 0;
        if ((v.mask != 2'b00) && (v.commit || v.memset)) begin
            maxK = 0;
            if (v.mask[0]) maxK = v.k0;
            if (v.mask[1] && v.k1 > maxK) maxK = v.k1;
            v.expBusy  = (v.drain + 1) + (maxK + 2) + 1;
            v.expStart = v.drain + 1;
            lastCommit = v.commit ? v.mask : 2'b00;
            lastMemset = v.memset ? v.mask : 2'b00;
            lastClear  = v.clear;
            if (v.commit) begin
                modelTile = (modelTile + 1) % 4;
                if (modelTile == 0) v.expFrameDone = 1;
            end
        end
        v.expTile      = 3'(modelTile);
        v.expCmdCommit = lastCommit;
        v.expCmdMemset = lastMemset;
        v.expClear     = lastClear;
    endtask

    // Issue one command, play the pipeline/applied side, then compare the outcome
    task automatic applyStimulus(input vec_t v, input string tag);
        int         busyCnt;
        int         startCyc;
        int         fdCnt;
        int         seen[2];
        logic [1:0] firstApply;
        logic [1:0] c0Commit;
        logic [1:0] c0Memset;
        logic [31:0] c0Clear;
        bit         unstable;
        bit         finished;
        busyCnt = 0; startCyc = -1; fdCnt = 0; seen[0] = 0; seen[1] = 0;
        firstApply = 2'b00; c0Commit = 2'b00; c0Memset = 2'b00; c0Clear = 32'h0;
        unstable = 1'b0; finished = 1'b0;

        @(negedge aclk);
        s_cmd_tvalid    = 1'b1;
        s_cmd_commit    = v.commit;
        s_cmd_memset    = v.memset;
        s_cmd_mask      = v.mask;
        s_cmd_clear     = v.clear;
        pixelInPipeline = (v.drain > 0);
        applied         = 2'b00;
        @(posedge aclk);

        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            s_cmd_tvalid = 1'b0;
            if (frameDone) fdCnt++;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            busyCnt++;
            if (c == 0) begin
                c0Commit = cmdCommit; c0Memset = cmdMemset; c0Clear = clearValue;
            end else if (cmdCommit != c0Commit || cmdMemset != c0Memset || clearValue != c0Clear) begin
                unstable = 1'b1;
            end
            if (apply != 2'b00 && startCyc < 0) begin
                startCyc   = c;
                firstApply = apply;
            end
            pixelInPipeline = (c < v.drain);
            for (int i = 0; i < 2; i++) begin
                int kk;
                kk = (i == 0) ? v.k0 : v.k1;
                if (apply[i]) begin
                    applied[i] = (seen[i] == kk);
                    seen[i]++;
                end else begin
                    applied[i] = v.mask[i] ? 1'b0 : 1'($urandom_range(1, 0));
                end
            end
        end
        applied         = 2'b00;
        pixelInPipeline = 1'b0;

        checkOutput({tag, " returnedIdle"}, finished, 1);
        checkOutput({tag, " busyCycles"}, busyCnt, v.expBusy);
        checkOutput({tag, " frameDone"}, fdCnt, v.expFrameDone);
        checkOutput({tag, " tileIndex"}, tileIndex, v.expTile);
        checkOutput({tag, " cmdCommit"}, cmdCommit, v.expCmdCommit);
        checkOutput({tag, " cmdMemset"}, cmdMemset, v.expCmdMemset);
        checkOutput({tag, " clearValue"}, clearValue, v.expClear);
        checkOutput({tag, " regsStable"}, unstable, 0);
        checkOutput({tag, " tready"}, s_cmd_tready, 1);
        if (v.expBusy > 0) begin
            checkOutput({tag, " applyStart"}, startCyc, v.expStart);
            checkOutput({tag, " applyFirst"}, firstApply, v.mask);
            checkOutput({tag, " apply0Cycles"}, seen[0], v.mask[0] ? v.k0 + 1 : 0);
            checkOutput({tag, " apply1Cycles"}, seen[1], v.mask[1] ? v.k1 + 1 : 0);
        end
    endtask

    initial begin
        vec_t v;
        int   fd;
        int   hi;
        bit   fin;

        // commit, memset, mask, clear, drain, k0, k1, busy, start, fd, tile, cmdCommit, cmdMemset, clear
        table_[0] = '{1'b1, 1'b0, 2'b11, 32'h1234_5678,  0, 2, 2,  6,  1, 0, 3'd1, 2'b11, 2'b00, 32'h1234_5678};
        table_[1] = '{1'b0, 1'b1, 2'b10, 32'hFFFF_0000, 10, 0, 0, 14, 11, 0, 3'd1, 2'b00, 2'b10, 32'hFFFF_0000};
        table_[2] = '{1'b1, 1'b0, 2'b11, 32'h0000_ABCD,  0, 0, 2,  6,  1, 0, 3'd2, 2'b11, 2'b00, 32'h0000_ABCD};
        table_[3] = '{1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF,  0, 0, 0,  0, -1, 0, 3'd2, 2'b11, 2'b00, 32'h0000_ABCD};
        table_[4] = '{1'b0, 1'b0, 2'b11, 32'h1111_1111,  0, 0, 0,  0, -1, 0, 3'd2, 2'b11, 2'b00, 32'h0000_ABCD};
        table_[5] = '{1'b1, 1'b1, 2'b01, 32'h0000_5555,  1, 1, 0,  6,  2, 0, 3'd3, 2'b01, 2'b01, 32'h0000_5555};
        table_[6] = '{1'b1, 1'b0, 2'b10, 32'hAAAA_0000,  0, 0, 0,  4,  1, 1, 3'd0, 2'b10, 2'b00, 32'hAAAA_0000};

        resetn = 1'b0; s_cmd_tvalid = 1'b0; s_cmd_commit = 1'b0; s_cmd_memset = 1'b0;
        s_cmd_mask = 2'b00; s_cmd_clear = 32'h0; pixelInPipeline = 1'b0; applied = 2'b00;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset tready", s_cmd_tready, 1);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset apply", apply, 0);
        checkOutput("reset tileIndex", tileIndex, 0);
        checkOutput("reset frameDone", frameDone, 0);
        checkOutput("reset error", error, 0);
        checkOutput("reset cmdCommit", cmdCommit, 0);
        checkOutput("reset cmdMemset", cmdMemset, 0);
        checkOutput("reset clearValue", clearValue, 0);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(table_[i], $sformatf("vec%0d", i));

        modelTile = 0; lastCommit = 2'b10; lastMemset = 2'b00; lastClear = 32'hAAAA_0000;
        for (int r = 0; r < 40; r++) begin
            v.commit = 1'($urandom_range(1, 0));
            v.memset = 1'($urandom_range(1, 0));
            v.mask   = 2'($urandom_range(3, 0));
            v.clear  = $urandom;
            v.drain  = $urandom_range(3, 0);
            v.k0     = $urandom_range(3, 0);
            v.k1     = $urandom_range(3, 0);
            modelExpect(v);
            applyStimulus(v, $sformatf("rnd%0d", r));
        end

        // Make sure the tile counter is away from zero before the mid-APPLY reset
        for (int n = 0; n < 4 && modelTile == 0; n++) begin
            v = '{1'b1, 1'b0, 2'b01, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 3'd0, 2'b00, 2'b00, 32'h0};
            modelExpect(v);
            applyStimulus(v, $sformatf("preRst%0d", n));
        end

        @(negedge aclk);
        s_cmd_tvalid = 1'b1; s_cmd_commit = 1'b1; s_cmd_memset = 1'b0;
        s_cmd_mask = 2'b11; s_cmd_clear = 32'h0F0F_0F0F; pixelInPipeline = 1'b0; applied = 2'b00;
        @(posedge aclk);
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            s_cmd_tvalid = 1'b0;
            if (apply != 2'b00) break;
        end
        checkOutput("rst applyBefore", apply, 2'b11);
        resetn = 1'b0;
        @(negedge aclk);
        checkOutput("rst apply", apply, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst tready", s_cmd_tready, 1);
        checkOutput("rst tileIndex", tileIndex, 0);
        checkOutput("rst cmdCommit", cmdCommit, 0);
        checkOutput("rst error", error, 0);
        resetn = 1'b1;
        fd = 0;
        repeat (5) begin
            @(negedge aclk);
            if (frameDone) fd++;
        end
        checkOutput("rst noFrameDone", fd, 0);
        modelTile = 0; lastCommit = 2'b00; lastMemset = 2'b00; lastClear = 32'h0;

`ifdef BUFFER_CMD_TIMEOUT_EN
        @(negedge aclk);
        s_cmd_tvalid = 1'b1; s_cmd_commit = 1'b1; s_cmd_memset = 1'b0;
        s_cmd_mask = 2'b11; s_cmd_clear = 32'h0; pixelInPipeline = 1'b0; applied = 2'b00;
        @(posedge aclk);
        hi = 0; fin = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge aclk);
            s_cmd_tvalid = 1'b0;
            if (!busy) begin
                fin = 1'b1;
                break;
            end
            if (apply != 2'b00) hi++;
        end
        checkOutput("tmo returnedIdle", fin, 1);
        checkOutput("tmo applyCycles", hi, 8);
        checkOutput("tmo error", error, 1);
        checkOutput("tmo tready", s_cmd_tready, 1);
        checkOutput("tmo tileIndex", tileIndex, 0);
        lastCommit = 2'b11; lastClear = 32'h0;
        v = '{1'b0, 1'b1, 2'b01, 32'h0000_00FF, 0, 1, 0, 0, 0, 0, 3'd0, 2'b00, 2'b00, 32'h0};
        modelExpect(v);
        applyStimulus(v, "postTmo");
        checkOutput("tmo errorSticky", error, 1);
`else
        hi = 0; fin = 1'b0;
        v = '{1'b1, 1'b0, 2'b11, 32'h0000_00FF, 2, 3, 1, 0, 0, 0, 3'd0, 2'b00, 2'b00, 32'h0};
        modelExpect(v);
        applyStimulus(v, "final");
        checkOutput("errorTiedLow", error, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
